// File: rtl/touch_adc_reader.sv
// ADS7843-style touch ADC reader: X/Y frames while the pen is down, averaged per set, strobed out.
// Optional build macro TOUCH_DUP_SUPPRESS_EN suppresses strobes that repeat the last emitted pair.
module touch_adc_reader #(
    parameter int unsigned CLK_DIV  = 50,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned GAP      = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iPENIRQ_n,
    input  logic        iADC_DOUT,
    output logic        oADC_CS_n,
    output logic        oADC_DCLK,
    output logic        oADC_DIN,
    output logic [11:0] x_coord,
    output logic [11:0] y_coord,
    output logic        new_coord
);

    localparam int unsigned ACC_W  = 12 + AVG_LOG2;
    localparam int unsigned DIV_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W  = (GAP > 2) ? $clog2(GAP) : 1;
    localparam int unsigned PAIR_W = AVG_LOG2 + 1;
    localparam int unsigned PAIRS  = 1 << AVG_LOG2;

    localparam logic [7:0] CMD_X     = 8'hD0;
    localparam logic [7:0] CMD_Y     = 8'h90;
    localparam logic [5:0] LAST_SLOT = 6'd49;
    localparam logic [5:0] FIRST_RX  = 6'd20;
    localparam logic [5:0] LAST_RX   = 6'd42;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FRAME_X,
        ST_FRAME_Y,
        ST_PAIR_CHECK,
        ST_EMIT,
        ST_GAP
    } state_t;

    state_t              state;
    logic                pen_meta;
    logic                pen_sync;
    logic                pen_down;
    logic [DIV_W-1:0]    div_cnt;
    logic [5:0]          slot;
    logic [5:0]          next_slot;
    logic                div_done;
    logic [7:0]          cmd;
    logic [7:0]          cmd_sh;
    logic [11:0]         rx_shift;
    logic [11:0]         x_sample;
    logic [ACC_W-1:0]    acc_x;
    logic [ACC_W-1:0]    acc_y;
    logic [PAIR_W-1:0]   pair_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [11:0]         avg_x;
    logic [11:0]         avg_y;
`ifdef TOUCH_DUP_SUPPRESS_EN
    logic [11:0]         last_x;
    logic [11:0]         last_y;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pen_meta <= 1'b1;
            pen_sync <= 1'b1;
        end else begin
            pen_meta <= iPENIRQ_n;
            pen_sync <= pen_meta;
        end
    end

    always_comb begin
        pen_down  = ~pen_sync;
        cmd       = (state == ST_FRAME_X) ? CMD_X : CMD_Y;
        div_done  = (div_cnt == DIV_W'(CLK_DIV - 1));
        next_slot = slot + 6'd1;
        avg_x     = 12'(acc_x >> AVG_LOG2);
        avg_y     = 12'(acc_y >> AVG_LOG2);
    end

    // A frame is 50 slots of CLK_DIV clocks: slot 0 is the CS-high gap, slot 1 drops CS,
    // slots 2..49 carry the 48 DCLK edges, and CS rises when slot 49 expires.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            oADC_CS_n <= 1'b1;
            oADC_DCLK <= 1'b0;
            oADC_DIN  <= 1'b0;
            x_coord   <= '0;
            y_coord   <= '0;
            new_coord <= 1'b0;
            div_cnt   <= '0;
            slot      <= '0;
            cmd_sh    <= '0;
            rx_shift  <= '0;
            x_sample  <= '0;
            acc_x     <= '0;
            acc_y     <= '0;
            pair_cnt  <= '0;
            gap_cnt   <= '0;
`ifdef TOUCH_DUP_SUPPRESS_EN
            last_x    <= '1;
            last_y    <= '1;
`endif
        end else begin
            new_coord <= 1'b0;
            case (state)
                ST_IDLE: begin
`ifdef TOUCH_DUP_SUPPRESS_EN
                    last_x <= '1;
                    last_y <= '1;
`endif
                    if (pen_down) begin
                        div_cnt <= '0;
                        slot    <= '0;
                        state   <= ST_FRAME_X;
                    end
                end

                ST_FRAME_X, ST_FRAME_Y: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        if (slot == LAST_SLOT) begin
                            slot      <= '0;
                            oADC_CS_n <= 1'b1;
                            oADC_DIN  <= 1'b0;
                            if (state == ST_FRAME_X) begin
                                x_sample <= rx_shift;
                                state    <= ST_FRAME_Y;
                            end else begin
                                state    <= ST_PAIR_CHECK;
                            end
                        end else begin
                            slot <= next_slot;
                            if (next_slot == 6'd1) begin
                                oADC_CS_n <= 1'b0;
                                oADC_DIN  <= cmd[7];
                                cmd_sh    <= {cmd[6:0], 1'b0};
                            end else if (!next_slot[0]) begin
                                oADC_DCLK <= 1'b1;
                                if (next_slot >= FIRST_RX && next_slot <= LAST_RX) begin
                                    rx_shift <= {rx_shift[10:0], iADC_DOUT};
                                end
                            end else begin
                                oADC_DCLK <= 1'b0;
                                oADC_DIN  <= cmd_sh[7];
                                cmd_sh    <= {cmd_sh[6:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                ST_PAIR_CHECK: begin
                    if (pair_cnt == PAIR_W'(PAIRS - 1)) begin
                        acc_x    <= acc_x + ACC_W'(x_sample);
                        acc_y    <= acc_y + ACC_W'(rx_shift);
                        pair_cnt <= pair_cnt + PAIR_W'(1);
                        state    <= ST_EMIT;
                    end else if (pen_down) begin
                        acc_x    <= acc_x + ACC_W'(x_sample);
                        acc_y    <= acc_y + ACC_W'(rx_shift);
                        pair_cnt <= pair_cnt + PAIR_W'(1);
                        // This clock is the first of the next inter-frame gap slot.
                        div_cnt  <= DIV_W'(1);
                        slot     <= '0;
                        state    <= ST_FRAME_X;
                    end else begin
                        acc_x    <= '0;
                        acc_y    <= '0;
                        pair_cnt <= '0;
                        state    <= ST_IDLE;
                    end
                end

                ST_EMIT: begin
`ifdef TOUCH_DUP_SUPPRESS_EN
                    if (avg_x != last_x || avg_y != last_y) begin
                        x_coord   <= avg_x;
                        y_coord   <= avg_y;
                        new_coord <= 1'b1;
                        last_x    <= avg_x;
                        last_y    <= avg_y;
                    end
`else
                    x_coord   <= avg_x;
                    y_coord   <= avg_y;
                    new_coord <= 1'b1;
`endif
                    acc_x    <= '0;
                    acc_y    <= '0;
                    pair_cnt <= '0;
                    gap_cnt  <= '0;
                    state    <= ST_GAP;
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_W'(GAP - 1)) begin
                        gap_cnt <= '0;
                        div_cnt <= '0;
                        slot    <= '0;
                        state   <= pen_down ? ST_FRAME_X : ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_touch_adc_reader.sv
// Directed bench for touch_adc_reader: two instances (4-pair and 1-pair averaging) sharing one ADC model.
module tb_touch_adc_reader;

    localparam int C       = 2;
    localparam int GAPC    = 200;
    localparam int LAT4    = 3 + 4 * 100 * C + 2;
    localparam int LAT1    = 3 + 1 * 100 * C + 2;
    localparam int PERIOD4 = 4 * 100 * C + GAPC + 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic pen0 = 1'b1;
    logic pen1 = 1'b1;
    logic adc_dout = 1'b0;
    logic sel = 1'b0;

    logic cs0, dclk0, din0, new0;
    logic cs1, dclk1, din1, new1;
    logic [11:0] x0, y0, x1, y1;

    always #5 clock = ~clock;

    touch_adc_reader #(.CLK_DIV(C), .AVG_LOG2(2), .GAP(GAPC)) dut0 (
        .clock(clock), .reset(reset), .iPENIRQ_n(pen0), .iADC_DOUT(adc_dout),
        .oADC_CS_n(cs0), .oADC_DCLK(dclk0), .oADC_DIN(din0),
        .x_coord(x0), .y_coord(y0), .new_coord(new0)
    );

    touch_adc_reader #(.CLK_DIV(C), .AVG_LOG2(0), .GAP(GAPC)) dut1 (
        .clock(clock), .reset(reset), .iPENIRQ_n(pen1), .iADC_DOUT(adc_dout),
        .oADC_CS_n(cs1), .oADC_DCLK(dclk1), .oADC_DIN(din1),
        .x_coord(x1), .y_coord(y1), .new_coord(new1)
    );

    // ADC model: decodes the command on DCLK rising edges 1..8 and shifts the
    // 12-bit result out on falling edges 9..20 so rising edges 10..21 see bits 11..0.
    logic m_cs, m_dclk, m_din;
    assign m_cs   = sel ? cs1 : cs0;
    assign m_dclk = sel ? dclk1 : dclk0;
    assign m_din  = sel ? din1 : din0;

    logic        m_prev_cs = 1'b1;
    logic        m_prev_dclk = 1'b0;
    int          m_rise = 0;
    int          m_fall = 0;
    int          m_frame = 0;
    int          m_xcnt = 0;
    int          x_base = 0;
    int          x_step = 0;
    int          y_val = 0;
    logic [7:0]  m_cmd = '0;
    logic [11:0] m_data = '0;
    logic [7:0]  cmd_log [8];

    always @(m_cs or m_dclk) begin
        if (m_prev_cs === 1'b1 && m_cs === 1'b0) begin
            m_rise = 0;
            m_fall = 0;
            m_cmd  = '0;
            adc_dout = 1'b0;
        end else if (m_cs === 1'b0 && m_prev_dclk === 1'b0 && m_dclk === 1'b1) begin
            m_rise++;
            if (m_rise <= 8) m_cmd = {m_cmd[6:0], m_din};
            if (m_rise == 8) begin
                cmd_log[3'(m_frame)] = m_cmd;
                if (m_cmd == 8'hD0) begin
                    m_data = 12'(x_base + x_step * m_xcnt);
                    m_xcnt++;
                end else begin
                    m_data = 12'(y_val);
                end
                m_frame++;
            end
        end else if (m_cs === 1'b0 && m_prev_dclk === 1'b1 && m_dclk === 1'b0) begin
            m_fall++;
            if (m_fall >= 9 && m_fall <= 20) adc_dout = m_data[4'(20 - m_fall)];
            else adc_dout = 1'b0;
        end
        m_prev_cs   = m_cs;
        m_prev_dclk = m_dclk;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_strobe(input int maxc, input bit which, output int lat);
        lat = -1;
        for (int k = 1; k <= maxc; k++) begin
            @(negedge clock);
            if ((which ? new1 : new0) === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic count_strobes(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            if (new0 === 1'b1) cnt++;
        end
    endtask

    initial begin
        int lat;
        int cnt;
        int bad;
        bit found;

        x_base = 12'h800; x_step = 0; y_val = 12'h400;
        repeat (3) @(negedge clock);
        check("rst_cs", 32'(cs0), 1);
        check("rst_dclk", 32'(dclk0), 0);
        check("rst_din", 32'(din0), 0);
        check("rst_x", 32'(x0), 0);
        check("rst_y", 32'(y0), 0);
        check("rst_new", 32'(new0), 0);
        check("rst1_cs", 32'(cs1), 1);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Constant samples, one set, commands and latency
        pen0 = 1'b0;
        wait_strobe(LAT4 + 100, 1'b0, lat);
        check("t1_latency", 32'(lat), LAT4);
        check("t1_x", 32'(x0), 32'h800);
        check("t1_y", 32'(y0), 32'h400);
        check("t1_cmd_x", 32'(cmd_log[0]), 32'hD0);
        check("t1_cmd_y", 32'(cmd_log[1]), 32'h90);
        pen0 = 1'b1;
        @(negedge clock);
        check("t1_strobe_width", 32'(new0), 0);
        count_strobes(PERIOD4 + 200, cnt);
        check("t1_single_strobe", 32'(cnt), 0);

        // Ramp 100..103 averages (truncated) to 101
        x_base = 100; x_step = 1; m_xcnt = 0; y_val = 7;
        pen0 = 1'b0;
        wait_strobe(LAT4 + 100, 1'b0, lat);
        check("t2_latency", 32'(lat), LAT4);
        check("t2_x", 32'(x0), 101);
        check("t2_y", 32'(y0), 7);
        pen0 = 1'b1;
        count_strobes(400, cnt);

        // Pen lifted after pair 2: set discarded, outputs hold
        x_base = 12'h200; x_step = 0; y_val = 12'h300;
        pen0 = 1'b0;
        repeat (450) @(negedge clock);
        pen0 = 1'b1;
        count_strobes(1200, cnt);
        check("t3_no_strobe", 32'(cnt), 0);
        check("t3_cs", 32'(cs0), 1);
        check("t3_dclk", 32'(dclk0), 0);
        check("t3_x_hold", 32'(x0), 101);
        check("t3_y_hold", 32'(y0), 7);
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            if (cs0 !== 1'b1) bad++;
        end
        check("t3_idle_quiet", 32'(bad), 0);

        // Reset in FRAME_Y of pair 2 with DCLK high
        x_base = 12'hFFF; y_val = 12'hFFF; m_xcnt = 0; m_frame = 0;
        pen0 = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clock);
            if (m_frame == 3 && m_rise == 6 && m_fall == 5) begin
                found = 1'b1;
                break;
            end
        end
        check("t4_reached_edge", 32'(found), 1);
        check("t4_pre_cs_low", 32'(cs0), 0);
        reset = 1'b1;
        #1;
        check("t4_cs_async", 32'(cs0), 1);
        check("t4_dclk_async", 32'(dclk0), 0);
        check("t4_x_clr", 32'(x0), 0);
        check("t4_y_clr", 32'(y0), 0);
        x_base = 12'hABC; y_val = 12'h123; m_xcnt = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        wait_strobe(LAT4 + 100, 1'b0, lat);
        check("t4_latency", 32'(lat), LAT4);
        check("t4_x", 32'(x0), 32'hABC);
        check("t4_y", 32'(y0), 32'h123);
        pen0 = 1'b1;
        count_strobes(400, cnt);

        // Held for three sets with identical samples, then a fresh press
        x_base = 12'h123; y_val = 12'h456;
        pen0 = 1'b0;
        count_strobes(LAT4 + 2 * PERIOD4 + 20, cnt);
        pen0 = 1'b1;
`ifdef TOUCH_DUP_SUPPRESS_EN
        check("t5_strobe_count", 32'(cnt), 1);
`else
        check("t5_strobe_count", 32'(cnt), 3);
`endif
        check("t5_x", 32'(x0), 32'h123);
        check("t5_y", 32'(y0), 32'h456);
        count_strobes(400, cnt);
        check("t5_after_release", 32'(cnt), 0);
        pen0 = 1'b0;
        wait_strobe(LAT4 + 100, 1'b0, lat);
        check("t5_repress_latency", 32'(lat), LAT4);
        check("t5_repress_x", 32'(x0), 32'h123);
        pen0 = 1'b1;
        count_strobes(400, cnt);

        // Single-pair averaging at the sample extremes
        sel = 1'b1;
        x_base = 4095; x_step = 0; y_val = 0; m_xcnt = 0;
        repeat (2) @(negedge clock);
        pen1 = 1'b0;
        wait_strobe(LAT1 + 100, 1'b1, lat);
        check("t6_latency", 32'(lat), LAT1);
        check("t6_x", 32'(x1), 4095);
        check("t6_y", 32'(y1), 0);
        pen1 = 1'b1;
        repeat (10) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
